// File: rtl/rr_burst_bus_mux.sv
// N-channel round-robin bus multiplexer with burst locking.
// Registers the granted channel's data onto a shared bus and honours backpressure.
module rr_burst_bus_mux #(
   parameter int WIDTH     = 32,
   parameter int NCH       = 4,
   parameter int MAX_BURST = 8,
   localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH-1:0]       req,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic                 out_ready,
   output logic [NCH-1:0]       ack,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   output logic [CHW-1:0]       out_ch
);

   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t           state, state_n;
   logic [CHW-1:0]   gch, gch_n;
   logic [CHW-1:0]   rr_ptr, rr_ptr_n;
   logic [BW-1:0]    beat_cnt, beat_cnt_n;
   logic [WIDTH-1:0] data_n;
   logic             valid_n;
   logic [CHW-1:0]   ch_n;

   logic [CHW-1:0]   pick;
   logic             found;
   logic [WIDTH-1:0] sel_data;
   logic             advance;
   logic             xfer;
   logic             last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         gch       <= '0;
         rr_ptr    <= '0;
         beat_cnt  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
      end else begin
         state     <= state_n;
         gch       <= gch_n;
         rr_ptr    <= rr_ptr_n;
         beat_cnt  <= beat_cnt_n;
         out_data  <= data_n;
         out_valid <= valid_n;
         out_ch    <= ch_n;
      end
   end

   // Descending scan so the smallest offset from rr_ptr wins.
   always_comb begin
      int idx;
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NCH) idx = idx - NCH;
         if (req[idx]) begin
            pick  = idx[CHW-1:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NCH; k++) begin
         if (gch == CHW'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      ack = '0;
      if (state == GRANT) begin
         for (int k = 0; k < NCH; k++) begin
            if (gch == CHW'(k)) ack[k] = 1'b1;
         end
      end
   end

   assign advance = !out_valid || out_ready;
   assign xfer    = (state == GRANT) && req[gch] && advance;
   assign last    = xfer && (beat_cnt == BW'(MAX_BURST - 1));

   always_comb begin
      state_n    = state;
      gch_n      = gch;
      rr_ptr_n   = rr_ptr;
      beat_cnt_n = beat_cnt;
      data_n     = out_data;
      valid_n    = out_valid;
      ch_n       = out_ch;

      if (xfer) begin
         data_n     = sel_data;
         ch_n       = gch;
         valid_n    = 1'b1;
         beat_cnt_n = beat_cnt + 1'b1;
      end else if (out_ready) begin
         valid_n = 1'b0;
      end

      unique case (state)
         IDLE: begin
            if (found) begin
               state_n    = GRANT;
               gch_n      = pick;
               beat_cnt_n = '0;
            end
         end
         GRANT: begin
            if (!req[gch] || last) begin
               state_n  = IDLE;
               rr_ptr_n = (gch == CHW'(NCH - 1)) ? '0 : gch + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rr_burst_bus_mux.sv
// Directed bench for rr_burst_bus_mux: default burst depth plus a
// MAX_BURST=2 instance sharing the same stimulus.
module tb_rr_burst_bus_mux;

   localparam int WIDTH = 32;
   localparam int NCH   = 4;
   localparam int CHW   = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NCH-1:0]       req;
   logic [NCH*WIDTH-1:0] in_data;
   logic                 out_ready;

   logic [NCH-1:0]   ack_a, ack_b;
   logic [WIDTH-1:0] data_a, data_b;
   logic             valid_a, valid_b;
   logic [CHW-1:0]   ch_a, ch_b;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   rr_burst_bus_mux #(.WIDTH(WIDTH), .NCH(NCH), .MAX_BURST(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data),
      .out_ready(out_ready), .ack(ack_a), .out_data(data_a),
      .out_valid(valid_a), .out_ch(ch_a)
   );

   rr_burst_bus_mux #(.WIDTH(WIDTH), .NCH(NCH), .MAX_BURST(2)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data),
      .out_ready(out_ready), .ack(ack_b), .out_data(data_b),
      .out_valid(valid_b), .out_ch(ch_b)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [3:0] a,
                        input logic v, input logic [31:0] d,
                        input logic [1:0] c);
      chk({tag, ".ack"}, 64'(ack_a), 64'(a));
      chk({tag, ".valid"}, 64'(valid_a), 64'(v));
      if (v) begin
         chk({tag, ".data"}, 64'(data_a), 64'(d));
         chk({tag, ".ch"}, 64'(ch_a), 64'(c));
      end
   endtask

   task automatic set_ch(input int k, input logic [31:0] d);
      in_data[k*WIDTH +: WIDTH] = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] g;
      rst_n     = 1'b0;
      req       = 4'b1111;
      out_ready = 1'b1;
      in_data   = '0;
      set_ch(0, 32'hFFAABBCC);
      set_ch(1, 32'h11111111);
      set_ch(2, 32'h22222222);
      set_ch(3, 32'h33333333);

      // reset with all channels requesting
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst.ack", 64'(ack_a), 64'h0);
         chk("rst.valid", 64'(valid_a), 64'h0);
         chk("rst.data", 64'(data_a), 64'h0);
         chk("rst.ch", 64'(ch_a), 64'h0);
         chk("rst.ackb", 64'(ack_b), 64'h0);
      end
      rst_n = 1'b1;
      req   = '0;
      tick();
      chk_a("idle", 4'b0000, 1'b0, 32'h0, 2'd0);

      // single burst of three beats from ch0
      req = 4'b0001;
      tick();
      chk_a("b.grant", 4'b0001, 1'b0, 32'h0, 2'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_a("b.beat", 4'b0001, 1'b1, 32'hFFAABBCC, 2'd0);
      end
      req = 4'b0000;
      tick();
      chk_a("b.rel", 4'b0000, 1'b0, 32'h0, 2'd0);

      // round robin, two-beat bursts, ch0/ch1 alternate
      do_reset();
      req = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         g = 2'(k % 2);
         tick();
         chk("rr.ack", 64'(ack_b), 64'(4'b0001 << g));
         tick();
         chk("rr.ack1", 64'(ack_b), 64'(4'b0001 << g));
         chk("rr.v1", 64'(valid_b), 64'h1);
         chk("rr.ch1", 64'(ch_b), 64'(g));
         tick();
         chk("rr.gap", 64'(ack_b), 64'h0);
         chk("rr.v2", 64'(valid_b), 64'h1);
         chk("rr.ch2", 64'(ch_b), 64'(g));
         chk("rr.d2", 64'(data_b),
             64'(g == 2'd0 ? 32'hFFAABBCC : 32'h11111111));
      end

      // backpressure on ch2
      req = 4'b0000;
      do_reset();
      req = 4'b0100;
      tick();
      chk_a("bp.grant", 4'b0100, 1'b0, 32'h0, 2'd0);
      tick();
      chk_a("bp.beat1", 4'b0100, 1'b1, 32'h22222222, 2'd2);
      out_ready = 1'b0;
      set_ch(2, 32'h22220001);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_a("bp.stall", 4'b0100, 1'b1, 32'h22222222, 2'd2);
         chk("bp.stallb", 64'(ack_b), 64'h4);
      end
      out_ready = 1'b1;
      tick();
      chk_a("bp.beat2", 4'b0100, 1'b1, 32'h22220001, 2'd2);
      chk("bp.relb", 64'(ack_b), 64'h0);
      req = 4'b0000;
      tick();
      chk_a("bp.rel", 4'b0000, 1'b0, 32'h0, 2'd0);

      // wrap: rr_ptr=3, ch3 then ch0
      req = 4'b1001;
      tick();
      chk_a("wr.g3", 4'b1000, 1'b0, 32'h0, 2'd0);
      tick();
      chk_a("wr.b3", 4'b1000, 1'b1, 32'h33333333, 2'd3);
      req = 4'b0001;
      tick();
      chk_a("wr.rel", 4'b0000, 1'b0, 32'h0, 2'd0);
      req = 4'b1001;
      tick();
      chk_a("wr.g0", 4'b0001, 1'b0, 32'h0, 2'd0);
      tick();
      chk_a("wr.b0", 4'b0001, 1'b1, 32'hFFAABBCC, 2'd0);

      // reset in the middle of a ch1 burst
      req = 4'b0000;
      do_reset();
      req = 4'b0010;
      tick();
      chk_a("mr.grant", 4'b0010, 1'b0, 32'h0, 2'd0);
      tick();
      chk_a("mr.beat1", 4'b0010, 1'b1, 32'h11111111, 2'd1);
      rst_n = 1'b0;
      tick();
      chk("mr.ack", 64'(ack_a), 64'h0);
      chk("mr.valid", 64'(valid_a), 64'h0);
      chk("mr.data", 64'(data_a), 64'h0);
      chk("mr.ch", 64'(ch_a), 64'h0);
      rst_n = 1'b1;
      req   = 4'b0011;
      tick();
      chk_a("mr.g0", 4'b0001, 1'b0, 32'h0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
